// File: rtl/layer_sequencer.sv
// Drives en_comp 0..nlayers-1 then en_sumchk nlayers-1..0 on a layer_top stack; optional watchdog via LAYER_SEQ_WATCHDOG_EN.
// Latency: accepted en -> en_comp[0] next cycle; each matching layer ready pulse -> next strobe next cycle.
// Backpressure: none; en is ignored while busy and stray or early ready pulses are dropped.
module layer_sequencer #(
    parameter int nlayers        = 4,
    parameter int nlbits         = $clog2(nlayers),
    parameter int timeout_cycles = 65535
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 en,
    input  logic [31:0]          id_in,
    output logic [31:0]          id,
    output logic [nlayers-1:0]   en_comp,
    input  logic [nlayers-1:0]   comp_ready_pulse,
    output logic [nlayers-1:0]   en_sumchk,
    input  logic [nlayers-1:0]   sumchk_ready_pulse,
    output logic [nlbits-1:0]    cur_layer,
    output logic                 busy,
    output logic                 ready_pulse,
    output logic                 ready,
    output logic                 err_pulse
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMP_GO,
        S_COMP_WAIT,
        S_SUM_GO,
        S_SUM_WAIT,
        S_DONE
    } state_t;

    localparam logic [nlbits-1:0] last_layer = nlbits'(nlayers - 1);

    generate
        if (nlayers < 2) begin : g_bad_nlayers
            $error("layer_sequencer: nlayers must be at least 2");
        end
        if (nlbits != $clog2(nlayers)) begin : g_bad_nlbits
            $error("layer_sequencer: nlbits is derived from nlayers and must not be overridden");
        end
        if (timeout_cycles < 1) begin : g_bad_timeout
            $error("layer_sequencer: timeout_cycles must be at least 1");
        end
    endgenerate

    state_t state;

    function automatic logic [nlayers-1:0] onehot(input logic [nlbits-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Only the pulse for the layer being waited on, in its own WAIT state, counts.
    logic comp_hit;
    logic sum_hit;
    assign comp_hit = (state == S_COMP_WAIT) && comp_ready_pulse[cur_layer];
    assign sum_hit  = (state == S_SUM_WAIT)  && sumchk_ready_pulse[cur_layer];

    logic wd_expired;
    logic wd_fire;

`ifdef LAYER_SEQ_WATCHDOG_EN
    localparam int              wd_w    = $clog2(timeout_cycles + 1);
    localparam logic [wd_w-1:0] wd_last = wd_w'(timeout_cycles - 1);

    logic [wd_w-1:0] wd_cnt;

    // Counts WAIT cycles of the current step; any non-WAIT state restarts it.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wd_cnt <= '0;
        end else if (state == S_COMP_WAIT || state == S_SUM_WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign wd_expired = (wd_cnt == wd_last);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= wd_fire;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign err_pulse  = 1'b0;
`endif

    assign wd_fire = wd_expired &&
                     (((state == S_COMP_WAIT) && !comp_hit) ||
                      ((state == S_SUM_WAIT)  && !sum_hit));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= S_IDLE;
            cur_layer   <= '0;
            id          <= '0;
            en_comp     <= '0;
            en_sumchk   <= '0;
            busy        <= 1'b0;
            ready_pulse <= 1'b0;
            ready       <= 1'b0;
        end else begin
            en_comp     <= '0;
            en_sumchk   <= '0;
            ready_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en) begin
                        id        <= id_in;
                        ready     <= 1'b0;
                        cur_layer <= '0;
                        en_comp   <= onehot('0);
                        busy      <= 1'b1;
                        state     <= S_COMP_GO;
                    end
                end
                S_COMP_GO: begin
                    state <= S_COMP_WAIT;
                end
                S_COMP_WAIT: begin
                    if (comp_hit) begin
                        if (cur_layer != last_layer) begin
                            cur_layer <= cur_layer + 1'b1;
                            en_comp   <= onehot(cur_layer + 1'b1);
                            state     <= S_COMP_GO;
                        end else begin
                            cur_layer <= last_layer;
                            en_sumchk <= onehot(last_layer);
                            state     <= S_SUM_GO;
                        end
                    end else if (wd_fire) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_SUM_GO: begin
                    state <= S_SUM_WAIT;
                end
                S_SUM_WAIT: begin
                    if (sum_hit) begin
                        if (cur_layer != '0) begin
                            cur_layer <= cur_layer - 1'b1;
                            en_sumchk <= onehot(cur_layer - 1'b1);
                            state     <= S_SUM_GO;
                        end else begin
                            ready_pulse <= 1'b1;
                            state       <= S_DONE;
                        end
                    end else if (wd_fire) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    // DONE is not IDLE, so an en coincident with ready_pulse is dropped.
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: table of full passes plus hand sequences for stray pulses, reset and back-to-back.
`timescale 1ns/1ps
module tb_layer_sequencer;
    localparam int NL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstb;
    logic          en;
    logic [31:0]   id_in;
    logic [31:0]   id;
    logic [NL-1:0] en_comp;
    logic [NL-1:0] en_sumchk;
    logic [NL-1:0] comp_ready_pulse;
    logic [NL-1:0] sumchk_ready_pulse;
    logic [1:0]    cur_layer;
    logic          busy;
    logic          ready_pulse;
    logic          ready;
    logic          err_pulse;

    logic [NL-1:0] auto_comp, auto_sum, man_comp, man_sum;
    assign comp_ready_pulse   = auto_comp | man_comp;
    assign sumchk_ready_pulse = auto_sum  | man_sum;

    layer_sequencer #(.nlayers(NL), .timeout_cycles(10)) dut (
        .clk                (clk),
        .rstb               (rstb),
        .en                 (en),
        .id_in              (id_in),
        .id                 (id),
        .en_comp            (en_comp),
        .comp_ready_pulse   (comp_ready_pulse),
        .en_sumchk          (en_sumchk),
        .sumchk_ready_pulse (sumchk_ready_pulse),
        .cur_layer          (cur_layer),
        .busy               (busy),
        .ready_pulse        (ready_pulse),
        .ready              (ready),
        .err_pulse          (err_pulse)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit auto_on = 1'b0;
    int lat = 1;
    int pend_cnt = 0;
    int pend_idx = 0;
    bit pend_sum = 1'b0;
    int comp_log[$];
    int sum_log[$];
    int rp_cnt = 0, rp_cyc = 0, id_bad = 0, multi_bad = 0, handoff_bad = 0, err_cnt = 0, err_cyc = 0;
    logic [31:0] exp_id = '0;
    logic prev_ready = 1'b0, prev_busy = 1'b0;

    typedef struct {
        int          lat;
        logic [31:0] id_val;
        int          exp_len;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: sample at the falling edge, log strobes and act as the layer stack.
    task automatic tick();
        int ci, si;
        @(negedge clk);
        cyc++;
        auto_comp = '0;
        auto_sum  = '0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                if (pend_sum) auto_sum[pend_idx] = 1'b1;
                else          auto_comp[pend_idx] = 1'b1;
            end
        end
        ci = -1;
        si = -1;
        for (int i = 0; i < NL; i++) begin
            if (en_comp[i])   ci = i;
            if (en_sumchk[i]) si = i;
        end
        if (ci >= 0) begin
            comp_log.push_back(ci);
            if (auto_on) begin pend_cnt = lat; pend_idx = ci; pend_sum = 1'b0; end
        end
        if (si >= 0) begin
            sum_log.push_back(si);
            if (auto_on) begin pend_cnt = lat; pend_idx = si; pend_sum = 1'b1; end
        end
        if ($countones(en_comp | en_sumchk) > 1) multi_bad++;
        if (ready_pulse) begin rp_cnt++; rp_cyc = cyc; end
        if (err_pulse) begin err_cnt++; err_cyc = cyc; end
        if (busy && id !== exp_id) id_bad++;
        if (ready && !prev_ready && (busy || !prev_busy)) handoff_bad++;
        prev_ready = ready;
        prev_busy  = busy;
    endtask

    task automatic man_pulse(input bit is_sum, input int idx);
        if (is_sum) man_sum[idx] = 1'b1;
        else        man_comp[idx] = 1'b1;
        tick();
        man_comp = '0;
        man_sum  = '0;
    endtask

    task automatic wait_rp(input int base, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (rp_cnt > base) got = 1'b1;
        end
    endtask

    function automatic logic [31:0] pack_log(input int q[$], input int base);
        logic [31:0] v = 32'h1;
        for (int i = base; i < q.size(); i++) v = (v << 4) | 32'(q[i]);
        return v;
    endfunction

    task automatic run_pass(input string tag, input int l, input logic [31:0] idv, input int exp_len);
        int cb, sb, rb, ib, mb, hb, eb, c0;
        bit got;
        auto_on = 1'b1;
        lat     = l;
        exp_id  = idv;
        cb = comp_log.size(); sb = sum_log.size(); rb = rp_cnt;
        ib = id_bad; mb = multi_bad; hb = handoff_bad; eb = err_cnt;
        id_in = idv;
        en    = 1'b1;
        c0    = cyc;
        tick();
        en    = 1'b0;
        id_in = ~idv;
        wait_rp(rb, 300, got);
        check({tag, " reached_ready"}, 32'(got), 32'd1);
        tick();
        tick();
        check({tag, " comp_order"}, pack_log(comp_log, cb), 32'h10123);
        check({tag, " sum_order"},  pack_log(sum_log, sb),  32'h13210);
        check({tag, " ready_pulse_count"}, 32'(rp_cnt - rb), 32'd1);
        check({tag, " pass_length"}, 32'(rp_cyc - c0), 32'(exp_len));
        check({tag, " id_stable"}, 32'(id_bad - ib), 32'd0);
        check({tag, " strobe_onehot"}, 32'(multi_bad - mb), 32'd0);
        check({tag, " busy_ready_handoff"}, 32'(handoff_bad - hb), 32'd0);
        check({tag, " end_busy_ready"}, {30'd0, busy, ready}, 32'd1);
        check({tag, " end_id"}, id, idv);
        check({tag, " no_err"}, 32'(err_cnt - eb), 32'd0);
    endtask

    initial begin
        int cb, sb, rb;
        bit got;
        vecs[0] = '{3, 32'h0000_1234, 33};
        vecs[1] = '{1, 32'hDEAD_BEEF, 17};
        vecs[2] = '{2, 32'hA5A5_A5A5, 25};
        vecs[3] = '{5, 32'h0000_0000, 49};

        rstb = 1'b0; en = 1'b0; id_in = 32'hFFFF_FFFF;
        auto_comp = '0; auto_sum = '0; man_comp = '0; man_sum = '0;
        tick();
        tick();
        check("reset id", id, 32'd0);
        check("reset ctl", {18'd0, busy, ready, ready_pulse, err_pulse, cur_layer, en_comp, en_sumchk}, 32'd0);
        rstb = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) begin
            run_pass($sformatf("vec%0d", v), vecs[v].lat, vecs[v].id_val, vecs[v].exp_len);
        end

        // Manual sequence: early pulse in GO, stray pulses and en mid-pass, then reset in SUM_WAIT.
        auto_on = 1'b0;
        exp_id  = 32'h5A5A_0001;
        id_in   = exp_id;
        cb = comp_log.size(); sb = sum_log.size(); rb = rp_cnt;
        en = 1'b1;
        tick();
        en = 1'b0;
        id_in = 32'hFFFF_FFFF;
        check("go0 strobe", {28'd0, en_comp}, 32'h1);
        man_pulse(1'b0, 0);
        tick();
        tick();
        check("go pulse ignored", {28'd0, en_comp}, 32'h0);
        check("go pulse ignored strobes", 32'(comp_log.size() - cb), 32'd1);
        man_pulse(1'b0, 0);
        check("comp1 strobe", {28'd0, en_comp}, 32'h2);
        tick();
        man_comp = 4'b0100;
        man_sum  = 4'b0010;
        en       = 1'b1;
        tick();
        man_comp = '0; man_sum = '0; en = 1'b0;
        tick();
        tick();
        check("stray comp strobes", 32'(comp_log.size() - cb), 32'd2);
        check("stray sum strobes", 32'(sum_log.size() - sb), 32'd0);
        check("stray cur_layer", {30'd0, cur_layer}, 32'd1);
        check("stray id", id, 32'h5A5A_0001);
        man_pulse(1'b0, 1);
        check("comp2 strobe", {28'd0, en_comp}, 32'h4);
        tick();
        man_pulse(1'b0, 2);
        tick();
        man_pulse(1'b0, 3);
        check("sum3 strobe", {26'd0, cur_layer, en_sumchk}, 32'h38);
        tick();
        man_pulse(1'b1, 3);
        check("sum2 strobe", {28'd0, en_sumchk}, 32'h4);
        tick();
        check("sum_wait2 state", {29'd0, busy, cur_layer}, 32'h6);
        #2 rstb = 1'b0;
        #1;
        check("async reset id", id, 32'd0);
        check("async reset ctl", {18'd0, busy, ready, ready_pulse, err_pulse, cur_layer, en_comp, en_sumchk}, 32'd0);
        tick();
        rstb = 1'b1;
        tick();
        check("reset no ready_pulse", 32'(rp_cnt - rb), 32'd0);

        run_pass("after_reset", 1, 32'hC0FF_EE00, 17);

        // Back-to-back: en during DONE is dropped, en in the following IDLE cycle starts pass two.
        auto_on = 1'b1;
        lat     = 1;
        exp_id  = 32'hB2B0_0001;
        id_in   = exp_id;
        rb      = rp_cnt;
        en      = 1'b1;
        tick();
        en = 1'b0;
        wait_rp(rb, 300, got);
        check("b2b first ready", 32'(got), 32'd1);
        id_in = 32'hB2B0_0002;
        en    = 1'b1;
        tick();
        check("b2b en in DONE ignored", {30'd0, busy, ready}, 32'd1);
        exp_id = 32'hB2B0_0002;
        tick();
        en = 1'b0;
        check("b2b accept", {26'd0, busy, ready, en_comp}, 32'h21);
        check("b2b id", id, 32'hB2B0_0002);
        rb = rp_cnt;
        wait_rp(rb, 300, got);
        check("b2b second ready", 32'(got), 32'd1);
        tick();
        check("b2b end", {30'd0, busy, ready}, 32'd1);

`ifdef LAYER_SEQ_WATCHDOG_EN
        begin
            int w1, eb;
            auto_on = 1'b0;
            exp_id  = 32'h0D06_0001;
            id_in   = exp_id;
            rb = rp_cnt; eb = err_cnt;
            en = 1'b1;
            tick();
            en = 1'b0;
            for (int i = 0; i < NL; i++) begin
                tick();
                man_pulse(1'b0, i);
            end
            tick();
            w1 = cyc;
            for (int i = 0; i < 30 && err_cnt == eb; i++) tick();
            check("wd err count", 32'(err_cnt - eb), 32'd1);
            check("wd err timing", 32'(err_cyc - w1), 32'd10);
            check("wd idle", {30'd0, busy, ready}, 32'd0);
            check("wd no ready_pulse", 32'(rp_cnt - rb), 32'd0);
            check("wd id kept", id, 32'h0D06_0001);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Top-level control stage that sits directly upstream of a stack of `nlayers` `layer_top` instances. It drives their `en_comp` and `en_sumchk` strobes and the shared `id`. It runs computation from the input-side layer (index 0) to the output layer (index `nlayers-1`), then runs sumcheck in reverse order. It reports completion of the whole proof pass with a ready pulse/level pair that matches the per-layer handshake style.

## Interface
Parameters:
- `nlayers`, 4, number of `layer_top` instances sequenced; must be ≥ 2.
- `nlbits`, `$clog2(nlayers)`, layer index width; do not override, elaboration error if overridden.
- `timeout_cycles`, 65535, watchdog limit per layer step; used only with the macro under Configuration.

Ports:
- `clk`, input, 1, sole clock, rising edge.
- `rstb`, input, 1, asynchronous active-low reset.
- `en`, input, 1, start request; one-cycle pulse, honoured only in IDLE.
- `id_in`, input, 32, id of the computation to run; sampled when `en` is accepted.
- `id`, output, 32, latched id fanned out to every layer's `id` input.
- `en_comp`, output, `nlayers`, one-hot one-cycle pulse to layer i's `en_comp`.
- `comp_ready_pulse`, input, `nlayers`, per-layer computation-done pulses.
- `en_sumchk`, output, `nlayers`, one-hot one-cycle pulse to layer i's `en_sumchk`.
- `sumchk_ready_pulse`, input, `nlayers`, per-layer sumcheck-done pulses.
- `cur_layer`, output, `nlbits`, index of the layer currently being driven.
- `busy`, output, 1, high in every state except IDLE.
- `ready_pulse`, output, 1, one cycle at end of a full pass.
- `ready`, output, 1, high from `ready_pulse` until the next accepted `en`.
- `err_pulse`, output, 1, one-cycle watchdog abort; constant 0 without the macro.

## Operation
- States: IDLE, COMP_GO, COMP_WAIT, SUM_GO, SUM_WAIT, DONE.
- IDLE: on `en`=1, latch `id_in` into `id`, clear `ready`, set `cur_layer`=0, go to COMP_GO.
- COMP_GO: assert `en_comp[cur_layer]` for exactly one cycle, go to COMP_WAIT.
- COMP_WAIT: wait for `comp_ready_pulse[cur_layer]`.
  - If `cur_layer` < `nlayers-1`: increment `cur_layer`, go to COMP_GO.
  - Otherwise: set `cur_layer`=`nlayers-1`, go to SUM_GO.
- SUM_GO: assert `en_sumchk[cur_layer]` for exactly one cycle, go to SUM_WAIT.
- SUM_WAIT: wait for `sumchk_ready_pulse[cur_layer]`.
  - If `cur_layer` > 0: decrement `cur_layer`, go to SUM_GO.
  - Otherwise: go to DONE.
- DONE: assert `ready_pulse` for one cycle, set `ready`=1, go to IDLE.
- Ready pulses from layers other than `cur_layer`, or arriving in any state other than the matching WAIT state, are ignored.
- `en` is ignored outside IDLE; `id` holds stable for the entire pass.
- The w0 interlocks (`comp_w0`, `w0_ready`, `w0_done_pulse`) are wired layer-to-layer and are not touched by this block.
- At most one bit of `en_comp | en_sumchk` is set in any cycle.

## Timing
- Reset (async assert of `rstb`=0): state=IDLE, `cur_layer`=0, `id`=0, all strobes 0, `busy`=0, `ready`=0, `ready_pulse`=0, `err_pulse`=0. Reset mid-pass aborts immediately with no pulse.
- `en` accepted at edge T → `en_comp[0]` high during cycle T+1.
- Ready pulse for the current layer seen at edge T → next strobe high during cycle T+1, or `ready_pulse` high during T+1 after layer 0 sumcheck.
- Minimum pass length with zero-latency layers is 4·`nlayers`+1 cycles from `en` to `ready_pulse`.
- A ready pulse arriving in the same cycle as the strobe that requests it (the GO state) is ignored.
- `en` coincident with `ready_pulse` is ignored, because the DONE state is not IDLE.

## Configuration
- `LAYER_SEQ_WATCHDOG_EN` defined:
  - A counter of width `$clog2(timeout_cycles+1)` clears on every GO state and increments in each WAIT cycle.
  - When it reaches `timeout_cycles` without the awaited pulse: assert `err_pulse` for one cycle, return to IDLE with `ready`=0, leave `id` latched.
- Not defined: no counter is built, `err_pulse` is tied to 0, and WAIT states wait indefinitely.

## Test plan
- `nlayers`=4, `en` with `id_in`=0x1234, each layer returns its ready pulse 3 cycles after its strobe → `en_comp` order 0,1,2,3; `en_sumchk` order 3,2,1,0; `id`=0x1234 throughout; `ready_pulse` exactly once; `busy` drops in the same cycle `ready` rises.
- Zero-latency layers (ready pulse the cycle after the strobe) → `ready_pulse` 17 cycles after `en` is accepted.
- Inject `comp_ready_pulse[2]` while waiting on layer 1, plus a second `en` mid-pass → no state change, no extra strobes, `id` unchanged.
- Assert `rstb`=0 during SUM_WAIT on layer 2 → all outputs return to reset values asynchronously; a new `en` after reset starts again at `en_comp[0]`.
- With `LAYER_SEQ_WATCHDOG_EN` and `timeout_cycles`=10, withhold `sumchk_ready_pulse[3]` → `err_pulse` 10 cycles into SUM_WAIT, `busy`=0, `ready`=0, no `ready_pulse`.
- Back-to-back passes with `en` asserted on the cycle after `ready_pulse` → second pass is accepted; `ready` clears on the accept edge.
